// File: rtl/screen_pkg.sv
// Shared timing constants, attribute layout and colour helpers for the screen scanner.
package screen_pkg;
  localparam logic [8:0] H_TOTAL        = 9'd448;
  localparam logic [8:0] V_TOTAL        = 9'd312;
  localparam logic [8:0] H_ACTIVE_START = 9'd8;
  localparam logic [8:0] H_ACTIVE_END   = 9'd263;
  localparam logic [8:0] H_BLANK_START  = 9'd328;
  localparam logic [8:0] H_BLANK_END    = 9'd423;
  localparam logic [8:0] HSYNC_START    = 9'd352;
  localparam logic [8:0] HSYNC_END      = 9'd383;
  localparam logic [8:0] V_ACTIVE       = 9'd192;
  localparam logic [8:0] V_BLANK_START  = 9'd248;
  localparam logic [8:0] V_BLANK_END    = 9'd255;
  localparam logic [8:0] VSYNC_START    = 9'd248;
  localparam logic [8:0] VSYNC_END      = 9'd251;
  localparam logic [12:0] ATTR_BASE     = 13'h1800;

  // Colour fields are {G,R,B}
  localparam int CB_B = 0;
  localparam int CB_R = 1;
  localparam int CB_G = 2;

  typedef struct packed {
    logic       flash;
    logic       bright;
    logic [2:0] paper;
    logic [2:0] ink;
  } attr_t;

  function automatic logic [2:0] pixel_colour(attr_t at, logic px, logic flip);
    logic [2:0] fg, bg;
    fg = at.ink;
    bg = at.paper;
    if (at.flash && flip) begin
      fg = at.paper;
      bg = at.ink;
    end
    return px ? fg : bg;
  endfunction
endpackage

// File: rtl/video_timing.sv
// Raster counters, frame counter and registered sync/blank; region flags for the current count.
module video_timing import screen_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       flash_phase,
  output logic       act,
  output logic       brd,
  output logic       hsync,
  output logic       vsync,
  output logic       blank
);
  logic [4:0] frame;
  logic h_blank, v_blank, h_act, v_act, blank_c, hs_c, vs_c;

  assign h_blank = (hcount >= H_BLANK_START) && (hcount <= H_BLANK_END);
  assign v_blank = (vcount >= V_BLANK_START) && (vcount <= V_BLANK_END);
  assign h_act   = (hcount >= H_ACTIVE_START) && (hcount <= H_ACTIVE_END);
  assign v_act   = vcount < V_ACTIVE;
  assign hs_c    = (hcount >= HSYNC_START) && (hcount <= HSYNC_END);
  assign vs_c    = (vcount >= VSYNC_START) && (vcount <= VSYNC_END);
  assign blank_c = h_blank || v_blank;
  assign act     = h_act && v_act;
  assign brd     = !blank_c && !act;
  assign flash_phase = frame[4];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
      frame  <= '0;
    end else if (ce) begin
      if (hcount == H_TOTAL - 9'd1) begin
        hcount <= '0;
        if (vcount == V_TOTAL - 9'd1) begin
          vcount <= '0;
          frame  <= frame + 5'd1;
        end else begin
          vcount <= vcount + 9'd1;
        end
      end else begin
        hcount <= hcount + 9'd1;
      end
    end
  end

  // Syncs and blank lag the counter by one ce, aligned with the colour register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b0;
    end else if (ce) begin
      hsync <= !hs_c;
      vsync <= !vs_c;
      blank <= blank_c;
    end
  end
endmodule

// File: rtl/screen_scan.sv
// ZX Spectrum screen reader: fetches bitmap/attribute bytes per 8-pixel cell and emits RGBI.
module screen_scan import screen_pkg::*; #(
  parameter logic [2:0] BORDER_DEFAULT = 3'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic [2:0]  border,
  input  logic        border_en,
  output logic [12:0] a,
  input  logic [7:0]  d,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic        i,
  output logic        hsync,
  output logic        vsync,
  output logic        blank
);
  logic [8:0] hcount, vcount;
  logic       flash_phase, act, brd, fetch;
  logic [7:0] y;
  logic [4:0] c;
  logic [7:0] bmp_lat, attr_lat, shifter;
  attr_t      attr_q;
  logic [2:0] col;
  logic       ib;

  video_timing u_tm (
    .clock(clock), .reset(reset), .ce(ce),
    .hcount(hcount), .vcount(vcount), .flash_phase(flash_phase),
    .act(act), .brd(brd), .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  assign y     = vcount[7:0];
  assign c     = hcount[7:3];
  assign fetch = (vcount < V_ACTIVE) && !hcount[8];

  // Cell pipeline: addr at slot 0/2, data two ce later, shifter reload at slot 7
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a        <= '0;
      bmp_lat  <= '0;
      attr_lat <= '0;
      shifter  <= '0;
      attr_q   <= '0;
    end else if (ce) begin
      shifter <= {shifter[6:0], 1'b0};
      if (fetch) begin
        case (hcount[2:0])
          3'd0: a <= {y[7:6], y[2:0], y[5:3], c};
          3'd2: begin
            bmp_lat <= d;
            a       <= ATTR_BASE + {3'b000, y[7:3], c};
          end
          3'd4: attr_lat <= d;
          3'd7: begin
            shifter <= bmp_lat;
            attr_q  <= attr_t'(attr_lat);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    col = '0;
    ib  = 1'b0;
    if (act) begin
      col = pixel_colour(attr_q, shifter[7], flash_phase);
      ib  = attr_q.bright;
    end else if (brd) begin
      col = border_en ? border : BORDER_DEFAULT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r <= 1'b0;
      g <= 1'b0;
      b <= 1'b0;
      i <= 1'b0;
    end else if (ce) begin
      g <= col[CB_G];
      r <= col[CB_R];
      b <= col[CB_B];
      i <= ib;
    end
  end
endmodule

// File: tb/tb_screen_scan.sv
// Directed bench for screen_scan: address, pixel, sync, border, flash, ce-rate and reset checks.
module tb_screen_scan;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0;
  logic [2:0]  border = 3'b000;
  logic        border_en = 1'b0;
  logic [12:0] a;
  logic [7:0]  d;
  logic        r, g, b, i, hsync, vsync, blank;

  logic [7:0]  mem [8192];
  logic [5:0]  cap [448];
  int n_cmp = 0;
  int n_bad = 0;
  int div = 1;
  int nsteps = 0;

  typedef struct { int h; logic [2:0] grb; logic ib; logic bl; logic hs; } pix_t;
  typedef struct { int v; int h; logic [12:0] ea; } adr_t;
  pix_t pix [20];
  adr_t adr [10];

  screen_scan #(.BORDER_DEFAULT(3'd1)) dut (
    .clock(clock), .reset(reset), .ce(ce), .border(border), .border_en(border_en),
    .a(a), .d(d), .r(r), .g(g), .b(b), .i(i),
    .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  always #5 clock = ~clock;
  always @(posedge clock) d <= mem[a];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One pixel: div-1 idle clocks then one clock with ce high; sample 1 time unit after the edge
  task automatic step();
    if (div > 1) begin
      ce = 1'b0;
      repeat (div - 1) @(posedge clock);
      #1;
    end
    ce = 1'b1;
    @(posedge clock);
    #1;
    if (div > 1) ce = 1'b0;
    nsteps++;
  endtask

  task automatic at_vh(int v, int h);
    while (nsteps < v * 448 + h + 1) step();
  endtask

  task automatic at_h(int h);
    do step(); while (((nsteps - 1) % 448) != h);
  endtask

  task automatic do_reset(bit chkit);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ce = (k % 2) == 1;
      @(posedge clock);
      #1;
    end
    release dut.u_tm.vcount;
    release dut.u_tm.frame;
    @(posedge clock);
    #1;
    if (chkit) begin
      chk("reset_a", 32'(a), 32'h0);
      chk("reset_syncs", {30'd0, hsync, vsync}, 32'h3);
      chk("reset_rgbi_blank", {27'd0, r, g, b, i, blank}, 32'h0);
    end
    ce = 1'b0;
    reset = 1'b1;
    nsteps = 0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int ti, hs_low, nmis;
    for (int k = 0; k < 8192; k++) mem[k] = k[7:0];
    mem[0] = 8'h80;
    mem[13'h1800] = 8'h47;

    pix = '{
      '{0,   3'b001, 1'b0, 1'b0, 1'b1}, '{7,   3'b001, 1'b0, 1'b0, 1'b1},
      '{8,   3'b111, 1'b1, 1'b0, 1'b1}, '{9,   3'b000, 1'b1, 1'b0, 1'b1},
      '{15,  3'b000, 1'b1, 1'b0, 1'b1}, '{16,  3'b000, 1'b0, 1'b0, 1'b1},
      '{23,  3'b001, 1'b0, 1'b0, 1'b1}, '{256, 3'b011, 1'b0, 1'b0, 1'b1},
      '{259, 3'b111, 1'b0, 1'b0, 1'b1}, '{263, 3'b111, 1'b0, 1'b0, 1'b1},
      '{264, 3'b001, 1'b0, 1'b0, 1'b1}, '{327, 3'b001, 1'b0, 1'b0, 1'b1},
      '{328, 3'b000, 1'b0, 1'b1, 1'b1}, '{351, 3'b000, 1'b0, 1'b1, 1'b1},
      '{352, 3'b000, 1'b0, 1'b1, 1'b0}, '{383, 3'b000, 1'b0, 1'b1, 1'b0},
      '{384, 3'b000, 1'b0, 1'b1, 1'b1}, '{423, 3'b000, 1'b0, 1'b1, 1'b1},
      '{424, 3'b001, 1'b0, 1'b0, 1'b1}, '{447, 3'b001, 1'b0, 1'b0, 1'b1}
    };
    adr = '{
      '{0, 0, 13'h0000}, '{0, 2, 13'h1800}, '{0, 8, 13'h0001}, '{0, 10, 13'h1801},
      '{0, 300, 13'h181F}, '{1, 0, 13'h0100}, '{1, 2, 13'h1800},
      '{8, 0, 13'h0020}, '{8, 2, 13'h1820}, '{8, 8, 13'h0021}
    };

    // Reset state and natural-run addresses
    do_reset(1'b1);
    foreach (adr[k]) begin
      at_vh(adr[k].v, adr[k].h);
      chk($sformatf("addr v=%0d h=%0d", adr[k].v, adr[k].h), 32'(a), 32'(adr[k].ea));
    end

    // Line 0 walk with ce tied high: colour/sync table, hsync width, capture
    do_reset(1'b0);
    ti = 0;
    hs_low = 0;
    for (int h = 0; h < 448; h++) begin
      step();
      cap[h] = {g, r, b, i, blank, hsync};
      if (!hsync) hs_low++;
      if (ti < 20 && pix[ti].h == h) begin
        chk($sformatf("pix h=%0d", h), {26'd0, g, r, b, i, blank, hsync},
            {26'd0, pix[ti].grb, pix[ti].ib, pix[ti].bl, pix[ti].hs});
        ti++;
      end
    end
    chk("hsync_low_width", hs_low, 32);

    // Same line with ce one clock in four
    do_reset(1'b0);
    div = 4;
    nmis = 0;
    for (int h = 0; h < 448; h++) begin
      step();
      if ({g, r, b, i, blank, hsync} !== cap[h]) nmis++;
    end
    chk("ce_div4_vs_tied", nmis, 0);
    div = 1;

    // Flash: frame 0 shows ink, frame 16 swaps to paper
    mem[0] = 8'hFF;
    mem[13'h1800] = 8'h87;
    do_reset(1'b0);
    at_h(8);
    chk("flash_f0_h8", {28'd0, g, r, b, i}, {28'd0, 3'b111, 1'b0});
    at_h(15);
    chk("flash_f0_h15", {28'd0, g, r, b, i}, {28'd0, 3'b111, 1'b0});
    do_reset(1'b0);
    force dut.u_tm.frame = 5'd16;
    at_h(8);
    chk("flash_f16_h8", {28'd0, g, r, b, i}, {28'd0, 3'b000, 1'b0});
    at_h(12);
    chk("flash_f16_h12", {28'd0, g, r, b, i}, {28'd0, 3'b000, 1'b0});
    mem[0] = 8'h80;
    mem[13'h1800] = 8'h47;

    // Deep lines reached by pinning vcount
    do_reset(1'b0);
    border_en = 1'b1;
    border = 3'b010;
    force dut.u_tm.vcount = 9'd64;
    at_h(0);
    chk("addr v=64", 32'(a), 32'h0800);
    force dut.u_tm.vcount = 9'd100;
    at_h(0);
    chk("addr v=100", 32'(a), 32'h0C80);
    at_h(300);
    chk("border_red_h300", {27'd0, r, g, b, i, blank}, {27'd0, 5'b10000});
    border = 3'b100;
    step();
    chk("border_change_next", {27'd0, r, g, b, i, blank}, {27'd0, 5'b01000});
    force dut.u_tm.vcount = 9'd191;
    at_h(248);
    chk("addr v=191 c31 bmp", 32'(a), 32'h17FF);
    at_h(250);
    chk("addr v=191 c31 attr", 32'(a), 32'h1AFF);
    at_h(300);
    chk("addr hold h300", 32'(a), 32'h1AFF);
    force dut.u_tm.vcount = 9'd192;
    at_h(0);
    chk("addr hold v=192", 32'(a), 32'h1AFF);
    at_h(8);
    chk("border v=192 h8", {27'd0, r, g, b, i, blank}, {27'd0, 5'b01000});
    force dut.u_tm.vcount = 9'd247;
    step();
    chk("vsync v=247", {30'd0, vsync, blank}, {30'd0, 2'b10});
    force dut.u_tm.vcount = 9'd248;
    step();
    chk("vsync v=248", {30'd0, vsync, blank}, {30'd0, 2'b01});
    force dut.u_tm.vcount = 9'd251;
    step();
    chk("vsync v=251", {30'd0, vsync, blank}, {30'd0, 2'b01});
    force dut.u_tm.vcount = 9'd252;
    step();
    chk("vsync v=252", {30'd0, vsync, blank}, {30'd0, 2'b11});
    force dut.u_tm.vcount = 9'd256;
    step();
    chk("vsync v=256", {30'd0, vsync, blank}, {30'd0, 2'b10});
    border_en = 1'b0;

    // Reset mid-fetch on line 50, then a clean line 0
    do_reset(1'b0);
    force dut.u_tm.vcount = 9'd50;
    at_h(100);
    do_reset(1'b1);
    at_h(0);
    chk("restart addr h0", 32'(a), 32'h0000);
    at_h(2);
    chk("restart addr h2", 32'(a), 32'h1800);
    at_h(8);
    chk("restart pix h8", {27'd0, g, r, b, i, blank}, {27'd0, 5'b11110});
    at_h(9);
    chk("restart pix h9", {27'd0, g, r, b, i, blank}, {27'd0, 5'b00010});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
